// File: rtl/mul_pkg.sv
// Shared definitions for the product accumulator slice.
//   DEF_DATA_W : default signed product width from the sequential multiplier
//   DEF_ACC_W  : default signed accumulator width (must be >= product width)
//   DEF_CNT_W  : default frame-length counter width
//   state_t    : accumulator FSM states (IDLE, ACCUM, HOLD)
package mul_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ACC_W  = 64;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Bus bundle between a product source / sum consumer and product_accumulator.
//
// Handshake rule for both channels (prod_*, sum_*): a transfer happens on a
// rising clk edge where valid and ready are both high. The source holds its
// data stable while valid is high and ready is low; ready may be driven
// without waiting for valid.
//
// Signals:
//   prod_valid, product, len, clear : source -> accumulator
//   prod_ready                      : accumulator -> source
//   sum_valid, sum, ovf, count      : accumulator -> consumer
//   sum_ready                       : consumer -> accumulator
// Modports: master = source/consumer side, slave = accumulator side.
interface product_accumulator_if #(
  parameter int DATA_W = mul_pkg::DEF_DATA_W,
  parameter int ACC_W  = mul_pkg::DEF_ACC_W,
  parameter int CNT_W  = mul_pkg::DEF_CNT_W
);

  logic                     prod_valid;
  logic                     prod_ready;
  logic signed [DATA_W-1:0] product;
  logic        [CNT_W-1:0]  len;
  logic                     clear;
  logic                     sum_valid;
  logic                     sum_ready;
  logic signed [ACC_W-1:0]  sum;
  logic                     ovf;
  logic        [CNT_W-1:0]  count;

  modport master (
    output prod_valid, product, len, clear, sum_ready,
    input  prod_ready, sum_valid, sum, ovf, count
  );

  modport slave (
    input  prod_valid, product, len, clear, sum_ready,
    output prod_ready, sum_valid, sum, ovf, count
  );

endinterface

// File: rtl/acc_adder.sv
// Combinational signed adder for the accumulator.
//   a, b : signed ACC_W operands (b is the sign-extended product)
//   y    : sum, wrapped modulo 2^ACC_W or clamped when SATURATE_EN is defined
//   ovf  : signed overflow of this add (operand signs equal, raw sign differs)
// Build option: `define SATURATE_EN clamps y to the most positive / most
// negative ACC_W value on overflow.
module acc_adder #(
  parameter int ACC_W = mul_pkg::DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] y,
  output logic                    ovf
);

  logic signed [ACC_W-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

`ifdef SATURATE_EN
  // Overflow direction follows the operand sign: both negative clamps low.
  // Once clamped, further adds in the same direction overflow again and
  // land on the same clamp value.
  always_comb begin
    y = raw;
    if (ovf) begin
      y = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign y = raw;
`endif

endmodule

// File: rtl/product_accumulator.sv
// Frame accumulator for signed multiplier products.
// Accepts `len` products per frame (len sampled on the first accept, 0 means
// 1), sums them sign-extended into an ACC_W accumulator, then presents the
// sum until the consumer takes it. `clear` aborts the current frame.
// Ports:
//   clk       : clock, all state on rising edge
//   reset     : asynchronous active-low reset
//   bus       : product_accumulator_if.slave (product and sum channels)
//   state_dbg : current FSM state
// Build option: SATURATE_EN (see acc_adder) selects clamping instead of wrap.
module product_accumulator
  import mul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic   clk,
  input  logic   reset,
  product_accumulator_if.slave bus,
  output state_t state_dbg
);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] prod_ext, add_y;
  logic [CNT_W-1:0]        count_q, count_d, count_inc;
  logic [CNT_W-1:0]        len_q, len_d, len_eff;
  logic                    ovf_q, ovf_d, add_ovf, accept;

  // Size cast of a signed operand sign-extends to ACC_W.
  assign prod_ext  = ACC_W'(bus.product);
  assign len_eff   = (bus.len == '0) ? CNT_W'(1) : bus.len;
  assign count_inc = count_q + CNT_W'(1);
  assign accept    = bus.prod_valid && bus.prod_ready;

  acc_adder #(.ACC_W(ACC_W)) u_add (
    .a   (acc_q),
    .b   (prod_ext),
    .y   (add_y),
    .ovf (add_ovf)
  );

  assign bus.prod_ready = (state_q != HOLD);
  assign bus.sum_valid  = (state_q == HOLD);
  assign bus.sum        = acc_q;
  assign bus.ovf        = ovf_q;
  assign bus.count      = count_q;
  assign state_dbg      = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    // clear outranks both the product accept and the sum handoff.
    if (bus.clear) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = prod_ext;
            count_d = CNT_W'(1);
            len_d   = len_eff;
            ovf_d   = 1'b0;
            state_d = (len_eff == CNT_W'(1)) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d   = add_y;
            count_d = count_inc;
            ovf_d   = ovf_q | add_ovf;
            if (count_inc == len_q) state_d = HOLD;
          end
        end
        HOLD: begin
          if (bus.sum_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
